mips_gpio_port: RTL

//  Parametrised memory-mapped GPIO peripheral for the MIPS multi-cycle core.

---
 rtl/mips_gpio_port.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mips_gpio_port.sv
// Memory-mapped GPIO port: OUT/DIR/IN registers, atomic SET/CLR/TGL, synchronised inputs.
// Define MIPS_GPIO_IRQ_EN to build the edge-triggered interrupt block (IRQ_EN/IRQ_ST, irq).
module mips_gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              re,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [WIDTH-1:0]  gpio_i,
  output logic [WIDTH-1:0]  gpio_o,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  typedef enum logic [ADDR_W-1:0] {
    REG_OUT    = ADDR_W'(0),
    REG_DIR    = ADDR_W'(1),
    REG_IN     = ADDR_W'(2),
    REG_SET    = ADDR_W'(3),
    REG_CLR    = ADDR_W'(4),
    REG_TGL    = ADDR_W'(5),
    REG_IRQ_EN = ADDR_W'(6),
    REG_IRQ_ST = ADDR_W'(7)
  } reg_e;

  logic [WIDTH-1:0]                  out_q, out_d;
  logic [WIDTH-1:0]                  dir_q, dir_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [31:0]                       rdata_q, rdata_d;
  logic [WIDTH-1:0]                  in_w;
  logic [WIDTH-1:0]                  wmask;
  logic                              unused_wdata;

  assign in_w         = sync_q[SYNC_STAGES-1];
  assign wmask        = wdata[WIDTH-1:0];
  assign unused_wdata = ^wdata;

`ifdef MIPS_GPIO_IRQ_EN
  // Fall enables exist only when both halves fit in the 32-bit register.
  localparam int              EN_W      = (WIDTH > 16) ? WIDTH : 2 * WIDTH;
  localparam logic [2:0]      WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [EN_W-1:0]  en_q, en_d;
  logic [WIDTH-1:0] st_q, st_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [2:0]       warm_q, warm_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] rise_en, fall_en, edge_hit;

  assign rise_en = en_q[WIDTH-1:0];
  if (WIDTH > 16) begin : g_no_fall
    assign fall_en = '0;
  end else begin : g_fall
    assign fall_en = en_q[EN_W-1:WIDTH];
  end

  // Edges are ignored until the synchroniser and prev register hold real pin data.
  assign edge_hit = (warm_q == WARM_DONE)
                  ? ((in_w & ~prev_q & rise_en) | (~in_w & prev_q & fall_en))
                  : '0;
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], gpio_i};
    rdata_d = '0;
`ifdef MIPS_GPIO_IRQ_EN
    en_d    = en_q;
    st_d    = st_q;
    prev_d  = in_w;
    warm_d  = (warm_q == WARM_DONE) ? warm_q : warm_q + 3'd1;
    irq_d   = |st_q;
`endif

    if (re) begin
      case (addr)
        REG_OUT:    rdata_d = 32'(out_q);
        REG_DIR:    rdata_d = 32'(dir_q);
        REG_IN:     rdata_d = 32'(in_w);
`ifdef MIPS_GPIO_IRQ_EN
        REG_IRQ_EN: rdata_d = 32'(en_q);
        REG_IRQ_ST: rdata_d = 32'(st_q);
`endif
        default:    rdata_d = '0;
      endcase
    end

    if (we) begin
      case (addr)
        REG_OUT:    out_d = wmask;
        REG_DIR:    dir_d = wmask;
        REG_SET:    out_d = out_q | wmask;
        REG_CLR:    out_d = out_q & ~wmask;
        REG_TGL:    out_d = out_q ^ wmask;
`ifdef MIPS_GPIO_IRQ_EN
        REG_IRQ_EN: en_d  = wdata[EN_W-1:0];
        REG_IRQ_ST: st_d  = st_q & ~wmask;
`endif
        default:    ;
      endcase
    end

`ifdef MIPS_GPIO_IRQ_EN
    st_d = st_d | edge_hit;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      dir_q   <= '0;
      sync_q  <= '0;
      rdata_q <= '0;
`ifdef MIPS_GPIO_IRQ_EN
      en_q    <= '0;
      st_q    <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
      irq_q   <= 1'b0;
`endif
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      sync_q  <= sync_d;
      rdata_q <= rdata_d;
`ifdef MIPS_GPIO_IRQ_EN
      en_q    <= en_d;
      st_q    <= st_d;
      prev_q  <= prev_d;
      warm_q  <= warm_d;
      irq_q   <= irq_d;
`endif
    end
  end

  assign rdata   = rdata_q;
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;

endmodule
